multiword_add_sequencer: RTL and testbench

- Streaming front-end for the N_BIT full_tree_adder; instantiates one full_tree_adder internally.
- Adds multi-word (multiprecision) operands delivered as a packet of N_BIT words, least-significant word first.
- Chains the carry between words through a register and returns one registered sum word per input word.
- carry_out and overflow are reported for the complete multi-word result on the last word.

---
 rtl/multiword_add_sequencer.sv | 130 +++++++++++++
 tb/tb_multiword_add_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// Streaming multiprecision adder: one registered sum word per input word, carry chained across the packet.
// Optional subtract mode (A - B) is compiled in with `define MULTIWORD_SUB_EN.

module full_tree_adder #(
    parameter int N_BIT = 64
) (
    input  logic [N_BIT-1:0] a,
    input  logic [N_BIT-1:0] b,
    input  logic             cin,
    output logic [N_BIT-1:0] sum,
    output logic             cout
);
    logic [N_BIT-1:0] prop;
    logic [N_BIT-1:0] gen_pre;
    logic [N_BIT-1:0] prop_pre;
    logic [N_BIT-1:0] gen_nxt;
    logic [N_BIT-1:0] prop_nxt;
    logic [N_BIT:0]   carry;

    // Kogge-Stone prefix: after the last level gen_pre[i]/prop_pre[i] span bits [i:0]
    always_comb begin
        prop     = a ^ b;
        gen_pre  = a & b;
        prop_pre = prop;
        gen_nxt  = '0;
        prop_nxt = '0;
        for (int d = 1; d < N_BIT; d = d * 2) begin
            gen_nxt  = gen_pre;
            prop_nxt = prop_pre;
            for (int i = d; i < N_BIT; i++) begin
                gen_nxt[i]  = gen_pre[i] | (prop_pre[i] & gen_pre[i-d]);
                prop_nxt[i] = prop_pre[i] & prop_pre[i-d];
            end
            gen_pre  = gen_nxt;
            prop_pre = prop_nxt;
        end
        carry[0] = cin;
        for (int i = 0; i < N_BIT; i++) begin
            carry[i+1] = gen_pre[i] | (prop_pre[i] & cin);
        end
        sum  = prop ^ carry[N_BIT-1:0];
        cout = carry[N_BIT];
    end
endmodule

module multiword_add_sequencer #(
    parameter int N_BIT = 64
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MULTIWORD_SUB_EN
    input  logic             op_sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic             carry_in,
    input  logic [N_BIT-1:0] operand_1,
    input  logic [N_BIT-1:0] operand_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [N_BIT-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    logic             first_word;
    logic             carry_reg;
    logic             in_fire;
    logic [N_BIT-1:0] b_eff;
    logic             cin_eff;
    logic [N_BIT-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;

    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;

`ifdef MULTIWORD_SUB_EN
    logic sub_reg;
    logic sub_now;

    // op_sub is only honoured on the first word; later words reuse the latched mode
    assign sub_now = first_word ? op_sub : sub_reg;
    assign b_eff   = sub_now ? ~operand_2 : operand_2;
    assign cin_eff = first_word ? (op_sub | carry_in) : carry_reg;
`else
    assign b_eff   = operand_2;
    assign cin_eff = first_word ? carry_in : carry_reg;
`endif

    full_tree_adder #(.N_BIT(N_BIT)) u_adder (
        .a    (operand_1),
        .b    (b_eff),
        .cin  (cin_eff),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign add_ovf = !(operand_1[N_BIT-1] ^ b_eff[N_BIT-1]) &
                     (add_sum[N_BIT-1] != operand_1[N_BIT-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            sum        <= '0;
            carry_out  <= 1'b0;
            overflow   <= 1'b0;
            carry_reg  <= 1'b0;
            first_word <= 1'b1;
`ifdef MULTIWORD_SUB_EN
            sub_reg    <= 1'b0;
`endif
        end else if (in_fire) begin
            out_valid  <= 1'b1;
            out_last   <= in_last;
            sum        <= add_sum;
            carry_out  <= in_last & add_cout;
            overflow   <= in_last & add_ovf;
            carry_reg  <= add_cout;
            first_word <= in_last;
`ifdef MULTIWORD_SUB_EN
            sub_reg    <= sub_now;
`endif
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer at N_BIT=8: directed vectors plus a short random packet sweep.
module tb_multiword_add_sequencer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_last, carry_in;
    logic [W-1:0] operand_1, operand_2, sum;
    logic         out_valid, out_ready, out_last, carry_out, overflow;
`ifdef MULTIWORD_SUB_EN
    logic         op_sub = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic         l;
        logic         c;
        logic         o;
    } exp_t;

    exp_t exp_q[$];
    time  pop_times[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_mode = 1'b0;

    multiword_add_sequencer #(.N_BIT(W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MULTIWORD_SUB_EN
        .op_sub    (op_sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .carry_in  (carry_in),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Monitor: output transfers are decided at the next rising edge; sample at the falling edge
    always @(negedge clk) begin : mon
        exp_t e;
        exp_t act;
        if (!rst && out_valid && out_ready) begin
            act = '{sum, out_last, carry_out, overflow};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got sum=%h last=%b cout=%b ovf=%b", sum, out_last, carry_out, overflow);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL out_word got sum=%h last=%b cout=%b ovf=%b want sum=%h last=%b cout=%b ovf=%b",
                             act.s, act.l, act.c, act.o, e.s, e.l, e.c, e.o);
                end
            end
            pop_times.push_back($time);
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    // Call at posedge+#1; returns at posedge+#1 after the word was accepted
    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                             input logic last, input exp_t e);
        int n;
        in_valid  = 1'b1;
        operand_1 = a;
        operand_2 = b;
        carry_in  = cin;
        in_last   = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready=%b want 1", in_ready);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_packet(input logic [31:0] a, input logic [31:0] b, input int nw, input logic cin);
        logic [31:0] mask, am, bm;
        logic [32:0] full;
        int          msb;
        exp_t        e;
        mask = (nw == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nw)) - 32'h1);
        am   = a & mask;
        bm   = b & mask;
        full = {1'b0, am} + {1'b0, bm} + {32'h0, cin};
        msb  = 8 * nw - 1;
        for (int k = 0; k < nw; k++) begin
            e.s = full[8*k +: 8];
            e.l = (k == nw - 1);
            e.c = e.l ? full[8*nw] : 1'b0;
            e.o = e.l ? ((am[msb] == bm[msb]) && (full[msb] != am[msb])) : 1'b0;
            send_word(am[8*k +: 8], bm[8*k +: 8], cin, e.l, e);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    vec_t singles[5] = '{
        '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
        '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0},
        '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
        '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0}
    };

    vec_t b2b[3] = '{
        '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0},
        '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0},
        '{8'hF0, 8'h10, 1'b1, 8'h01, 1'b1, 1'b0}
    };

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        carry_in  = 1'b0;
        operand_1 = '0;
        operand_2 = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        chk("reset_outputs", {21'h0, out_last, carry_out, overflow, sum}, 32'h0);
        @(posedge clk);
        #1;

        // carry chaining across two words
        send_packet(32'h00FF, 32'h0001, 2, 1'b0);

        foreach (singles[i])
            send_word(singles[i].a, singles[i].b, singles[i].cin, 1'b1,
                      '{singles[i].s, 1'b1, singles[i].c, singles[i].o});
        repeat (2) @(posedge clk);
        #1;

        // backpressure: second word must wait while the first output is stalled
        out_ready = 1'b0;
        fork
            send_packet(32'h00FF, 32'h0001, 2, 1'b0);
            begin
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_out_valid", 32'(out_valid), 32'h1);
                    chk("stall_in_ready", 32'(in_ready), 32'h0);
                    chk("stall_sum", {23'h0, out_last, sum}, 32'h000);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // reset mid-packet must drop the pending carry
        send_word(8'hFF, 8'h01, 1'b0, 1'b0, '{8'h00, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", 32'(out_valid), 32'h0);
        chk("midreset_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        send_word(8'h00, 8'h00, 1'b0, 1'b1, '{8'h00, 1'b1, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;

        // back-to-back single-word packets at full rate
        pop_times.delete();
        foreach (b2b[i])
            send_word(b2b[i].a, b2b[i].b, b2b[i].cin, 1'b1, '{b2b[i].s, 1'b1, b2b[i].c, b2b[i].o});
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_count", 32'(pop_times.size()), 32'd3);
        if (pop_times.size() == 3) begin
            chk("b2b_gap0", 32'(pop_times[1] - pop_times[0]), 32'd10);
            chk("b2b_gap1", 32'(pop_times[2] - pop_times[1]), 32'd10);
        end

`ifdef MULTIWORD_SUB_EN
        op_sub = 1'b1;
        send_word(8'h00, 8'h01, 1'b0, 1'b0, '{8'hFF, 1'b0, 1'b0, 1'b0});
        op_sub = 1'b0;
        send_word(8'h01, 8'h00, 1'b0, 1'b1, '{8'h00, 1'b1, 1'b1, 1'b0});
        repeat (2) @(posedge clk);
        #1;
`endif

        // random packets with random downstream stalls
        rand_mode = 1'b1;
        for (int p = 0; p < 24; p++)
            send_packet($urandom, $urandom, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        rand_mode = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
